// File: rtl/spi_master_6502.sv
// Memory-mapped SPI master (mode 0, 8-bit, MSB first) for the 6502 SoC bus.
// Registers: DATA, CTRL/STATUS, DIV, OVR-clear/RX-peek; registered read data.
module spi_master_6502 #(
   parameter logic [7:0] DIV_INIT = 8'd3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] rs,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       ss_n
);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   state_t     r_state;
   logic [7:0] r_div;
   logic [7:0] r_div_act;
   logic [7:0] r_cnt;
   logic [7:0] r_sh;
   logic [7:0] r_rx;
   logic [7:0] r_dout;
   logic [2:0] r_bits;
   logic       r_in;
   logic       r_busy;
   logic       r_done;
   logic       r_ovr;
   logic       r_ss;
   logic       r_irq_en;
   logic       r_irq;
   logic       r_sclk;
   logic       r_mosi;
   logic       r_ss_n;

   logic       w_wr;
   logic       w_rd;
   logic       w_edge;
   logic       w_finish;
   logic [7:0] w_status;

   assign w_wr     = cs & we;
   assign w_rd     = cs & ~we;
   assign w_edge   = (r_cnt == r_div_act);
   assign w_finish = (r_state == S_HIGH) && w_edge && (r_bits == 3'd7);
   assign w_status = {r_busy, r_done, r_ovr, 3'b000, r_irq_en, r_ss};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_div     <= DIV_INIT;
         r_div_act <= DIV_INIT;
         r_cnt     <= 8'd0;
         r_sh      <= 8'd0;
         r_rx      <= 8'd0;
         r_dout    <= 8'd0;
         r_bits    <= 3'd0;
         r_in      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovr     <= 1'b0;
         r_ss      <= 1'b0;
         r_irq_en  <= 1'b0;
         r_irq     <= 1'b0;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_ss_n    <= 1'b1;
      end else begin
         if (w_rd) begin
            case (rs)
               2'd1:    r_dout <= w_status;
               2'd2:    r_dout <= r_div;
               default: r_dout <= r_rx;
            endcase
         end

         if (w_wr && rs == 2'd1) begin
            r_ss     <= din[0];
            r_irq_en <= din[1];
            r_ss_n   <= ~din[0];
         end
         if (w_wr && rs == 2'd2) r_div <= din;

         // Setting always beats clearing for the sticky status flags.
         if (w_finish)                        r_done <= 1'b1;
         else if (w_rd && rs == 2'd0)         r_done <= 1'b0;
         if (w_wr && rs == 2'd0 && r_busy)    r_ovr  <= 1'b1;
         else if (w_wr && rs == 2'd3)         r_ovr  <= 1'b0;

         r_irq <= r_done & r_irq_en;

         case (r_state)
            S_IDLE: begin
               r_div_act <= r_div;
               if (w_wr && rs == 2'd0) begin
                  r_sh    <= din;
                  r_mosi  <= din[7];
                  r_busy  <= 1'b1;
                  r_cnt   <= 8'd0;
                  r_bits  <= 3'd0;
                  r_state <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_edge) begin
                  r_cnt     <= 8'd0;
                  r_div_act <= r_div;
                  r_sclk    <= 1'b1;
                  r_in      <= miso;
                  r_state   <= S_HIGH;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_HIGH: begin
               if (w_edge) begin
                  r_cnt     <= 8'd0;
                  r_div_act <= r_div;
                  r_sclk    <= 1'b0;
                  // Received bit is held aside until the falling edge so the
                  // outgoing LSB is not overwritten before it is shifted out.
                  if (r_bits == 3'd7) begin
                     r_rx    <= {r_sh[6:0], r_in};
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_sh    <= {r_sh[6:0], r_in};
                     r_mosi  <= r_sh[6];
                     r_bits  <= r_bits + 3'd1;
                     r_state <= S_LOW;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dout = r_dout;
   assign irq  = r_irq;
   assign sclk = r_sclk;
   assign mosi = r_mosi;
   assign ss_n = r_ss_n;

endmodule

// File: tb/tb_spi_master_6502.sv
// Directed bench for spi_master_6502: bus accesses on negedges, status polled
// continuously while a transfer runs, all expected values hand-derived.
module tb_spi_master_6502;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs;
   logic       we;
   logic [1:0] rs;
   logic [7:0] din;
   logic [7:0] dout;
   logic       irq;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       ss_n;
   logic       loop_en;
   logic       miso_val;

   int checks = 0;
   int errors = 0;

   assign miso = loop_en ? mosi : miso_val;

   spi_master_6502 #(.DIV_INIT(8'd3)) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .din(din),
      .dout(dout), .irq(irq), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; rs = a; din = d;
      @(posedge clk);
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; rs = a;
      @(posedge clk);
      @(negedge clk);
      cs = 1'b0;
      d = dout;
   endtask

   // Reads STATUS every clock until busy has been seen and then drops.
   task automatic poll(input int len, output int nbusy, output logic [7:0] first_st,
                       output logic [7:0] last_st, output logic [7:0] mbyte,
                       output int rises, output int bad);
      logic prev;
      int   run;
      cs = 1'b1; we = 1'b0; rs = 2'd1;
      nbusy = 0; rises = 0; bad = 0; mbyte = 8'h00; first_st = 8'h00; last_st = 8'h00;
      prev = sclk; run = 1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (sclk !== prev) begin
            if (run != len) bad++;
            run = 1;
            if (sclk) begin
               rises++;
               mbyte = {mbyte[6:0], mosi};
            end
            prev = sclk;
         end else begin
            run++;
         end
         last_st = dout;
         if (dout[7]) begin
            if (nbusy == 0) first_st = dout;
            nbusy++;
         end else if (nbusy > 0) begin
            break;
         end
      end
      cs = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] fst;
      logic [7:0] lst;
      logic [7:0] mb;
      int         nb;
      int         nr;
      int         nbad;

      reset = 1'b1; cs = 1'b0; we = 1'b0; rs = 2'd0; din = 8'h00;
      loop_en = 1'b0; miso_val = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dout", dout, 8'h00);
      check("rst_irq", irq, 1'b0);
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_ssn", ss_n, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      cpu_rd(2'd2, rd); check("rst_div", rd, 8'h03);
      cpu_rd(2'd1, rd); check("rst_status", rd, 8'h00);

      // Read latency and hold while cs is low
      cpu_wr(2'd2, 8'h5A);
      cs = 1'b1; we = 1'b0; rs = 2'd2;
      @(posedge clk); #1;
      check("lat_edge", dout, 8'h5A);
      @(negedge clk); cs = 1'b0;
      cpu_wr(2'd2, 8'h11);
      repeat (3) @(negedge clk);
      check("lat_hold", dout, 8'h5A);

      // Divider timing: DIV=7, miso=1, ctrl=0
      miso_val = 1'b1;
      cpu_wr(2'd2, 8'h07);
      cpu_rd(2'd1, rd); check("div_pre_st", rd, 8'h00);
      cpu_wr(2'd0, 8'h00);
      poll(8, nb, fst, lst, mb, nr, nbad);
      check("div_busy_clks", nb, 128);
      check("div_rises", nr, 8);
      check("div_bad_phase", nbad, 0);
      check("div_mosi", mb, 8'h00);
      check("div_first_st", fst, 8'h80);
      check("div_last_st", lst, 8'h40);
      cpu_rd(2'd3, rd); check("div_rx", rd, 8'hFF);
      cpu_rd(2'd1, rd); check("div_st_keep", rd, 8'h40);

      // Loopback: DIV=0, CTRL=3, DATA=A5 (done still set from above)
      cpu_wr(2'd2, 8'h00);
      cpu_wr(2'd1, 8'h03);
      check("irq_lag", irq, 1'b0);
      @(negedge clk);
      check("irq_rise", irq, 1'b1);
      check("ssn_on", ss_n, 1'b0);
      cpu_rd(2'd1, rd); check("lb_pre_st", rd, 8'h43);
      loop_en = 1'b1;
      cpu_wr(2'd0, 8'hA5);
      poll(1, nb, fst, lst, mb, nr, nbad);
      check("lb_busy_clks", nb, 16);
      check("lb_rises", nr, 8);
      check("lb_bad_phase", nbad, 0);
      check("lb_mosi", mb, 8'hA5);
      check("lb_busy_st", fst, 8'hC3);
      check("lb_done_st", lst, 8'h43);
      check("lb_irq", irq, 1'b1);
      cpu_rd(2'd0, rd); check("lb_rx", rd, 8'hA5);
      cpu_rd(2'd1, rd); check("lb_st_clr", rd, 8'h03);
      check("lb_irq_drop", irq, 1'b0);

      // Overrun: DIV=2, second write sampled on clock 5
      cpu_wr(2'd2, 8'h02);
      cpu_wr(2'd0, 8'h3C);
      repeat (4) @(negedge clk);
      cs = 1'b1; we = 1'b1; rs = 2'd0; din = 8'hFF;
      @(negedge clk);
      we = 1'b0;
      poll(3, nb, fst, lst, mb, nr, nbad);
      check("ovr_busy_clks", nb, 43);
      check("ovr_busy_st", fst, 8'hA3);
      check("ovr_done_st", lst, 8'h63);
      cpu_rd(2'd3, rd); check("ovr_rx", rd, 8'h3C);
      cpu_wr(2'd3, 8'h00);
      cpu_rd(2'd1, rd); check("ovr_cleared", rd, 8'h43);

      // Collision: DATA read on the completing edge
      cpu_wr(2'd2, 8'h00);
      cpu_rd(2'd0, rd); check("col_pre_rx", rd, 8'h3C);
      cpu_wr(2'd0, 8'h5A);
      repeat (15) @(negedge clk);
      cs = 1'b1; we = 1'b0; rs = 2'd0;
      @(negedge clk);
      check("col_old_rx", dout, 8'h3C);
      check("col_irq_lag", irq, 1'b0);
      rs = 2'd1;
      @(negedge clk);
      cs = 1'b0;
      check("col_done_kept", dout, 8'h43);
      check("col_irq", irq, 1'b1);
      cpu_rd(2'd3, rd); check("col_rx", rd, 8'h5A);

      // Collision: DATA write on the completing edge
      cpu_wr(2'd0, 8'h81);
      repeat (15) @(negedge clk);
      cs = 1'b1; we = 1'b1; rs = 2'd0; din = 8'h7E;
      @(negedge clk);
      we = 1'b0; rs = 2'd1;
      @(negedge clk);
      cs = 1'b0;
      check("colw_st", dout, 8'h63);
      repeat (4) @(negedge clk);
      cpu_rd(2'd1, rd); check("colw_idle", rd, 8'h63);
      cpu_rd(2'd3, rd); check("colw_rx", rd, 8'h81);

      // Reset mid-transfer: DIV=3, bit 4 high phase
      loop_en = 1'b0;
      cpu_wr(2'd2, 8'h03);
      cpu_wr(2'd0, 8'hFF);
      repeat (38) @(negedge clk);
      check("mid_sclk", sclk, 1'b1);
      check("mid_mosi", mosi, 1'b1);
      reset = 1'b1;
      #1;
      check("ar_sclk", sclk, 1'b0);
      check("ar_mosi", mosi, 1'b0);
      check("ar_ssn", ss_n, 1'b1);
      check("ar_irq", irq, 1'b0);
      check("ar_dout", dout, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      cpu_rd(2'd1, rd); check("ar_status", rd, 8'h00);
      cpu_rd(2'd2, rd); check("ar_div", rd, 8'h03);
      repeat (5) @(negedge clk);
      check("ar_sclk_idle", sclk, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
